packet_scheduler: RTL and testbench

Sequences HDMI data-island packets into the packet assembler. It arbitrates between up to eight packet sources (audio clock regeneration, audio samples, InfoFrames and similar) and loads one packet per 32-pixel slot. Header and subpacket registers are held stable for the whole slot. It sits between the packet generators and the assembler in the `clk_pixel` domain, driven by the island timing from the video timing generator.

---
 rtl/hdmi_pkg.sv | 13 +
 rtl/round_robin_arbiter.sv | 35 +++
 rtl/packet_scheduler.sv | 169 ++++++++++++++++
 tb/tb_packet_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island definitions: slot geometry, null header, scheduler states.
package hdmi_pkg;

  localparam int unsigned PACKET_SLOT_LEN = 32;
  localparam logic [23:0] NULL_HEADER     = 24'h000000;
  localparam logic [4:0]  SLOT_LAST       = 5'(PACKET_SLOT_LEN - 1);

  typedef enum logic {
    IDLE,
    SEND
  } packet_sched_state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr_i, wrapping to 0.
module round_robin_arbiter #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [WIDTH-1:0] gnt_o,
  output logic [PW-1:0]    next_ptr_o
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] sel;
  logic             found;

  // Prefer requests at or above the pointer; fall back to the lowest request overall.
  always_comb begin
    upper      = '0;
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      upper[k] = req_i[k] && (k >= 32'(ptr_i));
    end
    sel = (|upper) ? upper : req_i;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (!found && sel[k]) begin
        found      = 1'b1;
        gnt_o[k]   = 1'b1;
        next_ptr_o = (k == WIDTH - 1) ? '0 : PW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: one packet per 32-pixel slot, source 0
// fixed priority, sources 1..N-1 round-robin, optional once-per-field limit.
module packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned            NUM_SOURCES    = 4,
  parameter logic [NUM_SOURCES-1:0] ONCE_PER_FRAME = 4'b1100
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic                              island_prepare,
  input  logic [4:0]                        island_packets,
  input  logic                              data_island_period,
  input  logic                              frame_start,
  input  logic [NUM_SOURCES-1:0]            src_req,
  input  logic [NUM_SOURCES-1:0][23:0]      src_header,
  input  logic [NUM_SOURCES-1:0][3:0][55:0] src_sub,
  output logic [NUM_SOURCES-1:0]            src_ack,
  output logic [23:0]                       header,
  output logic [3:0][55:0]                  sub,
  output logic                              packet_valid,
  output logic [2:0]                        packet_source,
  output logic                              protocol_error
);

  localparam int unsigned RRW = NUM_SOURCES - 1;
  localparam int unsigned PW  = (RRW > 1) ? $clog2(RRW) : 1;

  packet_sched_state_t    state_q;
  logic [4:0]             slot_cnt_q;
  logic [4:0]             remaining_q;
  logic [23:0]            hdr_q;
  logic [3:0][55:0]       sub_q;
  logic                   valid_q;
  logic [2:0]             src_q;
  logic [NUM_SOURCES-1:0] ack_q;
  logic                   err_q;
  logic [NUM_SOURCES-1:0] served_q;
  // Pointer is held relative to source 1: value 0 selects source 1.
  logic [PW-1:0]          rr_ptr_q;

  logic [NUM_SOURCES-1:0] eligible;
  logic [RRW-1:0]         rr_gnt;
  logic [PW-1:0]          rr_ptr_d;
  logic                   rr_hit;
  logic [NUM_SOURCES-1:0] grant_d;
  logic [23:0]            hdr_d;
  logic [3:0][55:0]       sub_d;
  logic [2:0]             src_d;
  logic                   load_d;

  assign eligible = src_req & ~(served_q & ONCE_PER_FRAME);

  round_robin_arbiter #(
    .WIDTH(RRW)
  ) u_rr (
    .req_i      (eligible[NUM_SOURCES-1:1]),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (rr_gnt),
    .next_ptr_o (rr_ptr_d)
  );

  assign rr_hit  = !eligible[0] && (|rr_gnt);
  assign grant_d = eligible[0] ? NUM_SOURCES'(1) : {rr_gnt, 1'b0};

  // Select header/subpackets of the winner; no winner yields a null packet.
  always_comb begin
    hdr_d = NULL_HEADER;
    sub_d = '0;
    src_d = '0;
    for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
      if (grant_d[s]) begin
        hdr_d = src_header[s];
        sub_d = src_sub[s];
        src_d = 3'(s);
      end
    end
  end

  // A load starts an island or lands on the final cycle of a non-final slot.
  always_comb begin
    load_d = 1'b0;
    if (state_q == IDLE) begin
      load_d = island_prepare && (island_packets != 5'd0);
    end else begin
      load_d = !island_prepare && data_island_period &&
               (slot_cnt_q == SLOT_LAST) && (remaining_q != 5'd0);
    end
  end

  // Served flags and round-robin pointer; a same-cycle grant wins over frame_start.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      served_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      served_q <= (served_q & ~{NUM_SOURCES{frame_start}}) |
                  (load_d ? (grant_d & ONCE_PER_FRAME) : '0);
      if (load_d && rr_hit) begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // Island FSM with registered packet outputs, ack pulse and sticky error.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_cnt_q  <= '0;
      remaining_q <= '0;
      hdr_q       <= NULL_HEADER;
      sub_q       <= '0;
      valid_q     <= 1'b0;
      src_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= '0;
      if (data_island_period) begin
        slot_cnt_q <= slot_cnt_q + 5'd1;
      end
      if (load_d) begin
        hdr_q   <= hdr_d;
        sub_q   <= sub_d;
        valid_q <= |grant_d;
        src_q   <= src_d;
        ack_q   <= grant_d;
      end
      case (state_q)
        IDLE: begin
          if (island_prepare) begin
            if (island_packets != 5'd0) begin
              remaining_q <= island_packets - 5'd1;
              slot_cnt_q  <= '0;
              state_q     <= SEND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (island_prepare) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (!data_island_period) begin
            err_q   <= 1'b1;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end else if (slot_cnt_q == SLOT_LAST) begin
            if (remaining_q != 5'd0) begin
              remaining_q <= remaining_q - 5'd1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_ack        = ack_q;
  assign header         = hdr_q;
  assign sub            = sub_q;
  assign packet_valid   = valid_q;
  assign packet_source  = src_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed self-checking bench for packet_scheduler (4 sources, sources 2/3 once per field).
module tb_packet_scheduler;

  localparam int unsigned N = 4;

  logic                    clk_pixel = 1'b0;
  logic                    reset;
  logic                    island_prepare;
  logic [4:0]              island_packets;
  logic                    data_island_period;
  logic                    frame_start;
  logic [N-1:0]            src_req;
  logic [N-1:0][23:0]      src_header;
  logic [N-1:0][3:0][55:0] src_sub;
  logic [N-1:0]            src_ack;
  logic [23:0]             header;
  logic [3:0][55:0]        sub;
  logic                    packet_valid;
  logic [2:0]              packet_source;
  logic                    protocol_error;

  int n_err    = 0;
  int n_checks = 0;
  logic [N-1:0] ack_seen;

  packet_scheduler #(
    .NUM_SOURCES    (N),
    .ONCE_PER_FRAME (4'b1100)
  ) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .island_prepare     (island_prepare),
    .island_packets     (island_packets),
    .data_island_period (data_island_period),
    .frame_start        (frame_start),
    .src_req            (src_req),
    .src_header         (src_header),
    .src_sub            (src_sub),
    .src_ack            (src_ack),
    .header             (header),
    .sub                (sub),
    .packet_valid       (packet_valid),
    .packet_source      (packet_source),
    .protocol_error     (protocol_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Pulse island_prepare, then raise data_island_period for the island body.
  task automatic start_island(input logic [4:0] n);
    island_prepare = 1'b1;
    island_packets = n;
    tick();
    island_prepare     = 1'b0;
    island_packets     = 5'd0;
    data_island_period = 1'b1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_island_period = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_load(input string tag, input int unsigned s, input logic v);
    logic [N-1:0]       exp_ack;
    logic [23:0]        exp_hdr;
    logic [3:0][55:0]   exp_sub;
    exp_ack = v ? (N'(1) << s) : '0;
    exp_hdr = v ? src_header[s] : 24'h0;
    exp_sub = v ? src_sub[s] : '0;
    chk({tag, "_ack"},    src_ack,      exp_ack);
    chk({tag, "_header"}, header,       exp_hdr);
    chk({tag, "_sub"},    sub,          exp_sub);
    chk({tag, "_valid"},  packet_valid, v);
    if (v) chk({tag, "_source"}, packet_source, s);
  endtask

  initial begin
    reset              = 1'b1;
    island_prepare     = 1'b0;
    island_packets     = 5'd0;
    data_island_period = 1'b0;
    frame_start        = 1'b0;
    src_req            = '0;
    src_header[0] = 24'h000082;
    src_header[1] = 24'h000101;
    src_header[2] = 24'h000184;
    src_header[3] = 24'h0D0203;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 4; j++) begin
        src_sub[i][j] = {8'(i), 8'(j), 40'h5A5A5A5A5A};
      end
    end

    // Reset state
    ticks(2);
    chk("rst_header", header, 24'h0);
    chk("rst_sub", sub, '0);
    chk("rst_valid", packet_valid, 1'b0);
    chk("rst_ack", src_ack, 4'b0000);
    chk("rst_source", packet_source, 3'd0);
    chk("rst_error", protocol_error, 1'b0);
    reset = 1'b0;
    tick();

    // Single-slot island, only source 2
    src_req = 4'b0100;
    start_island(5'd1);
    check_load("single", 2, 1'b1);
    src_req = '0;
    tick();
    chk("single_ack_pulse", src_ack, 4'b0000);
    ticks(30);
    chk("single_hold31", header, 24'h000184);
    tick();
    chk("single_after_hdr", header, 24'h000184);
    chk("single_after_valid", packet_valid, 1'b1);
    data_island_period = 1'b0;
    tick();
    chk("single_idle_noerr", protocol_error, 1'b0);

    // Mixed requests: 0, 1, 3 over three slots
    do_reset();
    src_req = 4'b1011;
    start_island(5'd3);
    check_load("mix1", 0, 1'b1);
    src_req[0] = 1'b0;
    ticks(32);
    check_load("mix2", 1, 1'b1);
    ticks(32);
    check_load("mix3", 3, 1'b1);
    ticks(32);
    data_island_period = 1'b0;
    tick();
    chk("mix_noerr", protocol_error, 1'b0);

    // Next field: pointer wrapped to 1, so 1 then 3
    pulse_frame();
    src_req = 4'b1010;
    start_island(5'd2);
    check_load("rr1", 1, 1'b1);
    ticks(32);
    check_load("rr2", 3, 1'b1);
    ticks(32);
    data_island_period = 1'b0;
    tick();

    // Per-field limit on source 3
    src_req = 4'b1000;
    pulse_frame();
    start_island(5'd2);
    check_load("pf1", 3, 1'b1);
    ticks(32);
    check_load("pf2_null", 0, 1'b0);
    ticks(32);
    data_island_period = 1'b0;
    tick();
    pulse_frame();
    start_island(5'd1);
    check_load("pf3", 3, 1'b1);
    ticks(32);
    data_island_period = 1'b0;
    src_req = '0;
    tick();

    // Empty island: two null packets, never an ack
    ack_seen = '0;
    start_island(5'd2);
    check_load("empty1", 0, 1'b0);
    for (int i = 0; i < 32; i++) begin tick(); ack_seen |= src_ack; end
    check_load("empty2", 0, 1'b0);
    for (int i = 0; i < 32; i++) begin tick(); ack_seen |= src_ack; end
    data_island_period = 1'b0;
    tick();
    chk("empty_no_ack", ack_seen, 4'b0000);
    chk("empty_noerr", protocol_error, 1'b0);

    // Abort: data_island_period drops at slot_cnt 10 of slot 1 of 2
    src_req = 4'b0010;
    start_island(5'd2);
    check_load("abort_load", 1, 1'b1);
    src_req = '0;
    ticks(10);
    data_island_period = 1'b0;
    tick();
    chk("abort_error", protocol_error, 1'b1);
    chk("abort_valid", packet_valid, 1'b0);
    src_req = 4'b0010;
    start_island(5'd1);
    check_load("abort_idle_reload", 1, 1'b1);
    ticks(32);
    data_island_period = 1'b0;
    src_req = '0;
    tick();
    chk("abort_sticky", protocol_error, 1'b1);

    // island_packets = 0
    do_reset();
    chk("zero_pre_err", protocol_error, 1'b0);
    src_req = 4'b0010;
    island_prepare = 1'b1;
    island_packets = 5'd0;
    tick();
    island_prepare = 1'b0;
    chk("zero_error", protocol_error, 1'b1);
    chk("zero_ack", src_ack, 4'b0000);
    chk("zero_valid", packet_valid, 1'b0);
    src_req = '0;

    // island_prepare during SEND is an error and is not honoured
    do_reset();
    src_req = 4'b0001;
    start_island(5'd2);
    check_load("prep_load", 0, 1'b1);
    ticks(5);
    island_prepare = 1'b1;
    island_packets = 5'd1;
    tick();
    island_prepare = 1'b0;
    island_packets = 5'd0;
    chk("prep_error", protocol_error, 1'b1);
    chk("prep_no_ack", src_ack, 4'b0000);
    chk("prep_header", header, 24'h000082);
    data_island_period = 1'b0;
    src_req = '0;
    tick();

    // Mid-island reset
    do_reset();
    src_req = 4'b1010;
    start_island(5'd2);
    check_load("mid_load", 1, 1'b1);
    ticks(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_header", header, 24'h0);
    chk("mid_rst_sub", sub, '0);
    chk("mid_rst_valid", packet_valid, 1'b0);
    chk("mid_rst_ack", src_ack, 4'b0000);
    chk("mid_rst_source", packet_source, 3'd0);
    chk("mid_rst_error", protocol_error, 1'b0);
    data_island_period = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start_island(5'd1);
    check_load("mid_after", 1, 1'b1);
    ticks(32);
    data_island_period = 1'b0;
    tick();
    chk("mid_after_noerr", protocol_error, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
